// File: rtl/instruction_fetch_unit.sv
// Fetch stage between the program counter and decode: req/ack instruction read, registered hand-off to decode.
// Optional ack-timeout watchdog is compiled in when IFU_TIMEOUT_EN is defined.
module instruction_fetch_unit #(
  parameter int unsigned   ADDR_W         = 32,
  parameter int unsigned   DATA_W         = 32,
  parameter logic [31:0]   NOP_INSTR      = 32'h0000_0000,
  parameter int unsigned   TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              decode_ready,
  output logic              pc_inc,
  output logic              fetch_error
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              inc_q, inc_d;
  logic              discard_q, discard_d;
  logic              blockFetch;

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign blockFetch  = err_q;
  assign fetch_error = err_q;
`else
  assign blockFetch  = 1'b0;
  assign fetch_error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    valid_d   = valid_q;
    inc_d     = 1'b0;
    discard_d = discard_q;
`ifdef IFU_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (fetch_en && !blockFetch) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack) begin
`ifdef IFU_TIMEOUT_EN
          cnt_d = '0;
`endif
          // A flush seen earlier or in this very cycle makes the returning word stale.
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = fetch_en ? FETCH : IDLE;
            req_d     = fetch_en;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_in;
            valid_d = 1'b1;
            inc_d   = 1'b1;
            state_d = HOLD;
            req_d   = 1'b0;
          end
        end else begin
          if (flush) begin
            discard_d = 1'b1;
          end
`ifdef IFU_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_d     = 1'b1;
            req_d     = 1'b0;
            state_d   = IDLE;
            cnt_d     = '0;
            discard_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        if (flush || decode_ready) begin
          valid_d = 1'b0;
          state_d = fetch_en ? FETCH : IDLE;
          req_d   = fetch_en;
          if (flush) begin
            instr_d = NOP_INSTR[DATA_W-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      instr_q   <= NOP_INSTR[DATA_W-1:0];
      ipc_q     <= '0;
      valid_q   <= 1'b0;
      inc_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      valid_q   <= valid_d;
      inc_q     <= inc_d;
      discard_q <= discard_d;
    end
  end

`ifdef IFU_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign imem_req    = req_q;
  assign imem_addr   = req_q ? pc_in : '0;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign pc_inc      = inc_q;

endmodule
